// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase scheduler: lamp codes, approach indices
// and the phase state encoding.
package traffic_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_W = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_E = 2'd3;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } phase_e;

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/rr_dir_picker.sv
// Combinational round-robin picker: first set bit of req_i searching upward
// from start_i+1 with wrap, so start_i itself is considered last.
module rr_dir_picker (
  input  logic [3:0] req_i,
  input  logic [1:0] start_i,
  output logic [1:0] grant_o,
  output logic       valid_o
);

  logic [1:0] idx;

  always_comb begin
    grant_o = start_i;
    valid_o = 1'b0;
    idx     = start_i;
    for (int k = 1; k <= 4; k++) begin
      idx = start_i + 2'(k);
      if (!valid_o && req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-way phase scheduler (ALLRED -> GREEN -> YELLOW).
// Define EMERGENCY_PREEMPT_EN to add the emerg_req port and preemption.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN   = 10,
  parameter int GREEN_MAX   = 30,
  parameter int YELLOW_TIME = 4,
  parameter int ALLRED_TIME = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic [3:0] emerg_req,
`endif
  output logic [1:0] north_light,
  output logic [1:0] west_light,
  output logic [1:0] south_light,
  output logic [1:0] east_light,
  output logic [1:0] active_dir,
  output logic [1:0] dbg_state_o
);

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] GMAX    = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_M1    = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [3:0]       pending_q, pending_d;
  logic [1:0]       dir_q, dir_d;
  logic [7:0]       lamps_q, lamps_d;

  logic [3:0] req, own_mask;
  logic [1:0] rr_dir, em_dir;
  logic       rr_valid, em_valid;
  logic       ar_done, gap_out, max_out;

  assign req      = pending_q | sensor;
  assign own_mask = dir_onehot(dir_q);
  assign ar_done  = (t_q >= AR_M1);
  assign gap_out  = (t_q >= GMIN_M1) && !sensor[dir_q];
  assign max_out  = (t_q >= GMAX_M1) && ((req & ~own_mask) != 4'b0000);

  rr_dir_picker u_rr (
    .req_i   (req),
    .start_i (dir_q),
    .grant_o (rr_dir),
    .valid_o (rr_valid)
  );

`ifdef EMERGENCY_PREEMPT_EN
  // Start at E so the search begins at N: lowest set bit wins.
  rr_dir_picker u_em (
    .req_i   (emerg_req),
    .start_i (DIR_E),
    .grant_o (em_dir),
    .valid_o (em_valid)
  );
`else
  assign em_dir   = DIR_N;
  assign em_valid = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    dir_d   = dir_q;
    // Demand from the approach currently being served is not latched again;
    // it is already satisfied by the running green.
    pending_d = pending_q | ((state_q == ST_GREEN) ? (sensor & ~own_mask) : sensor);

    case (state_q)
      ST_ALLRED: begin
        if (ar_done && (em_valid || rr_valid)) begin
          state_d   = ST_GREEN;
          t_d       = '0;
          dir_d     = em_valid ? em_dir : rr_dir;
          pending_d = pending_d & ~dir_onehot(dir_d);
        end else if (!ar_done) begin
          t_d = t_q + ONE;
        end
      end
      ST_GREEN: begin
        if (t_q < GMAX) t_d = t_q + ONE;
        if (em_valid) begin
          if (em_dir != dir_q) begin
            state_d = ST_YELLOW;
            t_d     = '0;
          end
        end else if (gap_out || max_out) begin
          state_d = ST_YELLOW;
          t_d     = '0;
        end
      end
      ST_YELLOW: begin
        if (t_q >= Y_M1) begin
          state_d = ST_ALLRED;
          t_d     = '0;
        end else begin
          t_d = t_q + ONE;
        end
      end
      default: begin
        state_d = ST_ALLRED;
        t_d     = '0;
      end
    endcase

    lamps_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (dir_d == 2'(i)) begin
        if (state_d == ST_GREEN)       lamps_d[2*i +: 2] = LAMP_GREEN;
        else if (state_d == ST_YELLOW) lamps_d[2*i +: 2] = LAMP_YELLOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ALLRED;
      t_q       <= '0;
      pending_q <= '0;
      dir_q     <= DIR_E;
      lamps_q   <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      lamps_q   <= lamps_d;
    end
  end

  assign north_light = lamps_q[1:0];
  assign west_light  = lamps_q[3:2];
  assign south_light = lamps_q[5:4];
  assign east_light  = lamps_q[7:6];
  assign active_dir  = dir_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Demand-actuated four-way phase scheduler that drives the north/west/south/east lamp outputs of an intersection. It latches per-approach vehicle sensors and grants green to one approach at a time in round-robin order, skipping approaches with no demand. Each grant runs through green, yellow and all-red clearance under programmable timers. It replaces the fixed-cycle sequencer and keeps the same lamp port shape, so it drops into the existing intersection top and benches.

## Interface
- GREEN_MIN, 10: minimum green cycles per grant
- GREEN_MAX, 30: green cycles after which a contested grant is terminated
- YELLOW_TIME, 4: exact yellow cycles
- ALLRED_TIME, 2: minimum all-red clearance cycles
- CNT_W, 8: phase timer width; every timer parameter must fit; constraints are 1 ≤ GREEN_MIN ≤ GREEN_MAX, YELLOW_TIME ≥ 1, ALLRED_TIME ≥ 1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- sensor  in  4  level vehicle demand; bit0=N, 1=W, 2=S, 3=E
- emerg_req  in  4  emergency preempt request, same bit order (only with EMERGENCY_PREEMPT_EN)
- north_light, west_light, south_light, east_light  out  2 each  lamp code: 00 red, 01 yellow, 10 green; 11 never driven
- active_dir  out  2  index of the approach last granted

## Operation
- States: ALLRED, GREEN, YELLOW. Timer `t` is 0 on the first cycle of each state and saturates at GREEN_MAX in GREEN.
- `pending[i]` is set when `sensor[i]` is high. It is cleared on the cycle approach i enters GREEN; a set on the same cycle loses.
- The request vector is `req = pending | sensor`.
- ALLRED exit: once t ≥ ALLRED_TIME-1 and req ≠ 0, grant the first set bit of req searching from active_dir+1 upward, with wrap. If req = 0, rest in ALLRED, re-evaluating every cycle.
- GREEN:
  - `gap_out` = t ≥ GREEN_MIN-1 and own sensor low.
  - `max_out` = t ≥ GREEN_MAX-1 and another approach's req is set.
  - Either one moves to YELLOW.
  - Own sensor high with no other demand holds green indefinitely.
- YELLOW: exactly YELLOW_TIME cycles, then ALLRED.
- Only the granted approach shows non-red; all others are red.
- The granted approach's own re-demand during yellow or all-red is served after the other pending approaches.
- Reset: state ALLRED, t=0, pending=0, active_dir=3 (so N is searched first), all lamps 00. A reset mid-phase forces all-red on the next cycle.

## Timing
- All outputs are registered and update on the same edge as the state.
- With sensor[0] high before reset release, north is green from the 2nd rising edge with rst low.
- Green is visible for at least GREEN_MIN cycles. Yellow is visible for exactly YELLOW_TIME cycles. All-red lasts at least ALLRED_TIME cycles.
- A sensor pulse of 1 cycle is sufficient to register demand.

## Configuration
- `EMERGENCY_PREEMPT_EN` defined:
  - emerg_req port exists; lowest set bit wins.
  - If that approach is green, green holds regardless of timers.
  - If another approach is green, it enters YELLOW next cycle, ignoring GREEN_MIN. YELLOW and ALLRED are never shortened.
  - On ALLRED exit, the emergency approach is granted ahead of round-robin. active_dir is updated normally.
- Undefined: the port is absent and there is no preemption logic.

## Structure
- Package `traffic_pkg`: lamp codes (RED, YELLOW, GREEN), direction indices N/W/S/E, state enum.
- Sub-module `rr_dir_picker`: combinational. Takes req[3:0] and a 2-bit start index, returns a grant index plus a valid bit. It is reused for the emergency pick with start = 3.

## Test plan
- Reset, sensor=0 for 50 cycles -> all four lamps 00 throughout, active_dir=3.
- sensor=4'b0001 held 40 cycles after reset release, then 0 -> N green from cycle 2 until the sensor drop (held past 30), then 4 cycles yellow, then all-red rest.
- sensor=4'b1001 held constant:
  - N green exactly 30 cycles, yellow 4, all-red 2.
  - Then E green 30, and N and E keep alternating.
  - W and S stay 00.
- N green, single-cycle sensor[1] pulse at t=3, N sensor dropped at t=5 -> N green until t=9 (10 cycles), yellow 4, all-red 2, then W green.
- With EMERGENCY_PREEMPT_EN: N green at t=3, emerg_req=4'b1000 -> N yellow next cycle for 4 cycles, all-red 2, E green held while emerg_req high.
- rst asserted on the 2nd yellow cycle of W -> all lamps 00 next cycle, pending cleared, and no grant until new demand.
